// File: rtl/debug_display_ctrl.sv
// Time-multiplexed 8/4-digit hex display scanner for a 32-bit debug word.
// Per-frame snapshot keeps the shown value tear-free; all outputs are registered.
module debug_display_ctrl #(
  parameter int unsigned DIV        = 100000,
  parameter int unsigned BLANK      = 16,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic              sysClk,
  input  logic              sysRes,
  input  logic [31:0]       dataIn,
  input  logic              freeze,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frameStart
);

  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = $clog2(DIGITS);
  localparam logic        ON  = (ACTIVE_LOW == 0) ? 1'b1 : 1'b0;
  localparam logic        OFF = ~ON;

  logic [PW-1:0]     p;
  logic [IW-1:0]     idx;
  logic [31:0]       snap;
  logic              freeze_q;
  logic              tick;
  logic              boundary;
  logic              show;
  logic [4:0]        nib_base;
  logic [3:0]        nib;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic              fs_d;

  assign tick     = (p == PW'(DIV - 1));
  assign boundary = tick && (idx == IW'(DIGITS - 1));
  assign nib_base = 5'({idx, 2'b00});
  assign nib      = snap[nib_base +: 4];

  // With no blanking every cycle of a slot is a display cycle.
  if (BLANK == 0) begin : g_noblank
    assign show = 1'b1;
  end else begin : g_blank
    assign show = (p >= PW'(BLANK));
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Prescaler, digit sequencer and frame-boundary snapshot.
  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      p        <= '0;
      idx      <= '0;
      snap     <= '0;
      freeze_q <= 1'b0;
    end else begin
      p        <= tick ? '0 : p + PW'(1);
      freeze_q <= freeze;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      if (boundary && !freeze) snap <= dataIn;
    end
  end

  always_comb begin
    an_d  = {DIGITS{OFF}};
    seg_d = {7{OFF}};
    dp_d  = OFF;
    fs_d  = (p == '0) && (idx == '0);
    if (show) begin
      an_d[idx] = ON;
      seg_d     = glyph(nib) ^ {7{OFF}};
      if ((idx == '0) && freeze_q) dp_d = ON;
    end
  end

  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      an         <= {DIGITS{OFF}};
      seg        <= {7{OFF}};
      dp         <= OFF;
      frameStart <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frameStart <= fs_d;
    end
  end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Bench for debug_display_ctrl: two instances (8-digit active-low, 4-digit active-high)
// compared every cycle against a frame/slot arithmetic reference model.
module tb_debug_display_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] data_a, data_b;
  logic        frz_a, frz_b;
  logic [7:0]  an_a;
  logic [3:0]  an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fs_a, fs_b;

  int errors = 0;
  int checks = 0;

  debug_display_ctrl #(.DIV(4), .BLANK(1), .DIGITS(8), .ACTIVE_LOW(1)) dut_a (
    .sysClk(clk), .sysRes(rst), .dataIn(data_a), .freeze(frz_a),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frameStart(fs_a)
  );

  debug_display_ctrl #(.DIV(4), .BLANK(0), .DIGITS(4), .ACTIVE_LOW(0)) dut_b (
    .sysClk(clk), .sysRes(rst), .dataIn(data_b), .freeze(frz_b),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frameStart(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, cycle count since reset plus snapshot and freeze flag.
  int          dv_m  [2] = '{4, 4};
  int          bl_m  [2] = '{1, 0};
  int          dig_m [2] = '{8, 4};
  int          al_m  [2] = '{1, 0};
  logic [6:0]  gl    [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n_m   [2];
  logic [31:0] snap_m[2];
  logic        frzq_m[2];
  logic [7:0]  e_an  [2];
  logic [6:0]  e_seg [2];
  logic        e_dp  [2];
  logic        e_fs  [2];
  logic        e_show[2];

  task automatic reset_model(input int k);
    logic [7:0] mask;
    mask      = 8'((1 << dig_m[k]) - 1);
    n_m[k]    = 0;
    snap_m[k] = '0;
    frzq_m[k] = 1'b0;
    e_an[k]   = (al_m[k] != 0) ? mask : 8'h00;
    e_seg[k]  = (al_m[k] != 0) ? 7'h7F : 7'h00;
    e_dp[k]   = (al_m[k] != 0);
    e_fs[k]   = 1'b0;
    e_show[k] = 1'b1;
  endtask

  task automatic advance(input int k, input logic [31:0] din, input logic fz);
    int frame, pos, ph, d;
    logic show, inv;
    logic [7:0] mask, an_h;
    logic [31:0] sh;
    logic [6:0] seg_h;
    frame = dv_m[k] * dig_m[k];
    pos   = n_m[k] % frame;
    ph    = pos % dv_m[k];
    d     = pos / dv_m[k];
    show  = (ph >= bl_m[k]);
    inv   = (al_m[k] != 0);
    mask  = 8'((1 << dig_m[k]) - 1);
    an_h  = show ? 8'(1 << d) : 8'h00;
    sh    = snap_m[k] >> (4 * d);
    seg_h = show ? gl[sh[3:0]] : 7'h00;
    e_an[k]   = inv ? (~an_h & mask) : an_h;
    e_seg[k]  = inv ? ~seg_h : seg_h;
    e_dp[k]   = (show && d == 0 && frzq_m[k]) ^ inv;
    e_fs[k]   = (pos == 0);
    e_show[k] = show;
    if (pos == frame - 1 && !fz) snap_m[k] = din;
    frzq_m[k] = fz;
    n_m[k]    = n_m[k] + 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an_a", an_a, e_an[0]);
    if (e_show[0]) chk("seg_a", {1'b0, seg_a}, {1'b0, e_seg[0]});
    chk("dp_a", {7'b0, dp_a}, {7'b0, e_dp[0]});
    chk("fs_a", {7'b0, fs_a}, {7'b0, e_fs[0]});
    chk("an_b", {4'b0, an_b}, e_an[1]);
    if (e_show[1]) chk("seg_b", {1'b0, seg_b}, {1'b0, e_seg[1]});
    chk("dp_b", {7'b0, dp_b}, {7'b0, e_dp[1]});
    chk("fs_b", {7'b0, fs_b}, {7'b0, e_fs[1]});
  endtask

  // One clock: update model with inputs seen at the edge, then check at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      reset_model(0);
      reset_model(1);
    end else begin
      advance(0, data_a, frz_a);
      advance(1, data_b, frz_b);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  int pulses;

  initial begin
    rst    = 1'b1;
    data_a = 32'h0;
    data_b = 32'hDEAD0123;
    frz_a  = 1'b0;
    frz_b  = 1'b0;
    reset_model(0);
    reset_model(1);
    run(3);
    chk("reset_an_a", an_a, 8'hFF);
    chk("reset_seg_a", {1'b0, seg_a}, 8'h7F);

    // Release, then scan a known word through two frames.
    rst    = 1'b0;
    data_a = 32'h89ABCDEF;
    run(70);

    // frameStart period over exactly two frames.
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (fs_a) pulses++;
    end
    chk("fs_period", 8'(pulses), 8'd2);

    // Tear-free capture: change the word mid-frame.
    data_a = 32'h11111111;
    run(48);
    data_a = 32'h22222222;
    run(48);

    // Freeze across a boundary while the word changes.
    frz_a  = 1'b1;
    frz_b  = 1'b1;
    run(10);
    data_a = 32'h33333333;
    data_b = 32'h0000BEEF;
    run(40);
    frz_a  = 1'b0;
    frz_b  = 1'b0;
    run(40);

    // Randomized traffic with a mid-cycle asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) data_a = $urandom;
      if ($urandom_range(0, 7) == 0) data_b = $urandom;
      if ($urandom_range(0, 15) == 0) frz_a = ~frz_a;
      if ($urandom_range(0, 15) == 0) frz_b = ~frz_b;
      if (i == 200) begin
        #2 rst = 1'b1;
        #1;
        reset_model(0);
        reset_model(1);
        check_all();
        chk("async_an_a", an_a, 8'hFF);
        chk("async_fs_a", {7'b0, fs_a}, 8'h00);
        step();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_display_ctrl.md
# debug_display_ctrl

Scanning controller that time-multiplexes a 32-bit CPU debug word (register or PC value) onto an 8-digit common-anode seven-segment display as hexadecimal. It sits in the board-level debug top between the CPU debug tap and the display pins. It owns the refresh prescaler, the digit sequencer, inter-digit blanking and a per-frame snapshot, so a changing value never tears mid-frame.

## Interface

Parameters:
- DIV, 100000: sysClk cycles per digit slot; must be ≥ 2.
- BLANK, 16: leading cycles of each slot with all anodes off (anti-ghosting); 0 ≤ BLANK < DIV.
- DIGITS, 8: digit count; 4 or 8. Digit k shows nibble dataIn[4k+3:4k].
- ACTIVE_LOW, 1: 1 means an, seg and dp drive 0 for "on".

Ports:
- sysClk, input, 1: system clock.
- sysRes, input, 1: asynchronous, active-high reset.
- dataIn, input, 32: live debug word to display.
- freeze, input, 1: 1 holds the current snapshot (frames keep scanning).
- an, output, DIGITS: digit anode enables.
- seg, output, 7: segments {g,f,e,d,c,b,a}.
- dp, output, 1: decimal point.
- frameStart, output, 1: one-cycle pulse when a new frame (digit 0) begins.

## Operation

- Prescaler `p`, width $clog2(DIV): counts 0..DIV-1 and wraps to 0. `tick` = (p == DIV-1).
- Digit index `idx`, width $clog2(DIGITS): increments on tick; DIGITS-1 wraps to 0.
- Snapshot `snap[31:0]`: loads dataIn on a tick where idx == DIGITS-1 (the frame boundary), unless freeze == 1 in that cycle. freeze changes outside the boundary cycle have no effect until the next boundary.
- Slot phases, per value of p:
  - Blanking: p < BLANK. All anodes are inactive.
  - Display: p ≥ BLANK. Only an[idx] is active. seg shows the hex glyph of snap[4*idx+3 : 4*idx].
- Glyphs (a..g, 1 = lit, before polarity):
  - 0–9 use the standard patterns.
  - A, b, C, d, E and F use the standard patterns; b and d are lowercase.
  - The glyph table is the 16-entry ROM in the block.
- dp: lit only when idx == 0, in the display phase, and the registered freeze flag is 1. The registered freeze flag samples freeze every cycle.
- With DIGITS = 4, snap[31:16] is captured but never displayed.
- Polarity: the lit/active level is 1 XOR ACTIVE_LOW. It applies to an, seg and dp. frameStart is always active-high.

## Timing

- Reset (asynchronous assert; releases on the first sysClk edge after deassert):
  - p = 0, idx = 0, snap = 0, freeze flag = 0.
  - an, seg and dp all inactive (all 1 when ACTIVE_LOW = 1).
  - frameStart = 0.
- Reset mid-scan: outputs go inactive immediately. The first frame after release displays 0x00000000 until the first boundary.
- All outputs are registered. Each output reflects the state (p, idx, snap) of the previous cycle, so there is 1-cycle latency.
- frameStart is 1 in the cycle after a boundary tick, coincident with the first cycle of slot 0 on the outputs.
- A snapshot load and an idx wrap in the same edge are simultaneous. The new slot 0 shows the new snap nibble 0.
- Frame length is DIGITS*DIV cycles. Each digit is lit for DIV-BLANK cycles per frame.
- BLANK = 0: there is no blanking phase, and anodes switch directly between digits.

## Test plan

Bench settings are DIV=4, BLANK=1, DIGITS=8, ACTIVE_LOW=1.

1. Reset: hold sysRes, then assert it asynchronously mid-cycle.
   - Required: an=8'hFF, seg=7'h7F, dp=1 and frameStart=0 immediately.
   - Required after release: the first frame shows glyph "0" (seg=7'h40) on each digit during cycles p=1..3.
2. Scan order: dataIn=32'h89ABCDEF applied before the first boundary.
   - Required: frameStart pulses every 32 cycles.
   - Required in the second frame: an walks FE, FD, …, 7F, and seg shows F, E, d, C, b, A, 9, 8 for 3 cycles each.
   - Required: an=FF for 1 cycle between digits.
3. Tear-free capture: change dataIn mid-frame from 32'h11111111 to 32'h22222222.
   - Required: the rest of the frame shows "1" (seg=7'h79).
   - Required: the next frame shows "2" (seg=7'h24) on every digit.
4. Freeze: set freeze=1 across a boundary, then change dataIn.
   - Required: snap is unchanged and the old value is shown.
   - Required: dp=0 during the digit-0 display phase only.
   - Required: after freeze=0, the next boundary loads the new value.
5. Wrap and simultaneity: count cycles across 3 frames.
   - Required: idx returns to 0 exactly every 32 cycles.
   - Required: the snapshot load and slot-0 start align with frameStart.
   - Required: no cycle has two active anodes.
6. Parameter variant: DIGITS=4, BLANK=0, ACTIVE_LOW=0, dataIn=32'hDEAD0123.
   - Required: an cycles 1, 2, 4, 8 with no blank gap.
   - Required: seg shows 3, 2, 1, 0 (active-high glyphs); D, E, A and D are never shown.
